// File: rtl/flash_bridge.sv
// flash_bridge
// Turns single-cycle host requests into timed bus cycles on an asynchronous
// parallel NOR flash. Three operations are supported:
//   - read
//   - raw bus write
//   - two-phase program: command 0x40, then data, then a wait on the
//     flash ready/busy pin.
// The flash power-down pin is held low for a fixed time after reset.
// Every flash control is a flop output so that no glitches can reach the device.
module flash_bridge #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8,
    parameter int T_ACC  = 6,
    parameter int T_WP   = 4,
    parameter int RP_CYC = 16,
    parameter int STS_TO = 65535
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              NF_CE,
    output logic              NF_OE,
    output logic              NF_WE,
    output logic              NF_RP,
    output logic              NF_BYTE,
    output logic              NF_WP,
    output logic [ADDR_W-1:0] NF_A,
    inout  wire  [DATA_W-1:0] NF_D,
    input  logic              NF_STS
);

    // One shared counter times every phase, so it is sized for the longest one.
    // The extra headroom keeps the timeout compare free of wrap-around.
    localparam int CNT_MAX_A = (T_ACC > T_WP) ? T_ACC : T_WP;
    localparam int CNT_MAX_B = (RP_CYC > STS_TO) ? RP_CYC : STS_TO;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 2);

    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(RP_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] WP_LAST  = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] STS_LAST = CNT_W'(STS_TO - 1);
    localparam logic [CNT_W-1:0] STS_IGN  = CNT_W'(4);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_PROG  = 2'b10;

    // The program setup command is zero-extended to the bus width.
    localparam logic [DATA_W-1:0] CMD_PROG = DATA_W'(8'h40);

    typedef enum logic [3:0] {
        RSTW     = 4'd0,
        IDLE     = 4'd1,
        SETUP    = 4'd2,
        RD_ACC   = 4'd3,
        WR_PULSE = 4'd4,
        WR_HOLD  = 4'd5,
        REC      = 4'd6,
        STS_WAIT = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         op_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               phase2_r;
    logic               d_oe_r;
    logic [DATA_W-1:0]  d_out_r;
    logic               sts_meta_r;
    logic               sts_sync_r;
    logic               is_write_s;
    logic               is_prog_s;

    // Reserved opcode 11 falls through to the read path.
    assign is_write_s = (op_r == OP_WRITE) || (op_r == OP_PROG);
    assign is_prog_s  = (op_r == OP_PROG);

    // The data bus is driven only during write phases.
    // It is released at every other time, and in particular while NF_OE is low.
    assign NF_D    = d_oe_r ? d_out_r : {DATA_W{1'bz}};
    assign NF_BYTE = (DATA_W == 16) ? 1'b1 : 1'b0;
    assign NF_WP   = 1'b0;

    // Two-flop synchroniser for the asynchronous flash ready/busy pin
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            sts_meta_r <= 1'b0;
            sts_sync_r <= 1'b0;
        end else begin
            sts_meta_r <= NF_STS;
            sts_sync_r <= sts_meta_r;
        end
    end

    // Bus sequencer: state, phase counter and every registered host/flash output
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_r  <= RSTW;
            cnt_r    <= '0;
            op_r     <= 2'b00;
            wdata_r  <= '0;
            phase2_r <= 1'b0;
            d_oe_r   <= 1'b0;
            d_out_r  <= '0;
            ready    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            NF_A     <= '0;
            NF_CE    <= 1'b1;
            NF_OE    <= 1'b1;
            NF_WE    <= 1'b1;
            NF_RP    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                RSTW: begin
                    if (cnt_r == RP_LAST) begin
                        cnt_r   <= '0;
                        NF_RP   <= 1'b1;
                        ready   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (req) begin
                        op_r     <= op;
                        wdata_r  <= wdata;
                        NF_A     <= addr;
                        phase2_r <= 1'b0;
                        ready    <= 1'b0;
                        NF_CE    <= 1'b0;
                        state_r  <= SETUP;
                        if ((op == OP_WRITE) || (op == OP_PROG)) begin
                            d_oe_r  <= 1'b1;
                            d_out_r <= (op == OP_PROG) ? CMD_PROG : wdata;
                        end else begin
                            d_oe_r <= 1'b0;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SETUP: begin
                    cnt_r <= '0;
                    if (is_write_s) begin
                        NF_WE   <= 1'b0;
                        state_r <= WR_PULSE;
                    end else begin
                        NF_OE   <= 1'b0;
                        state_r <= RD_ACC;
                    end
                end
                RD_ACC: begin
                    if (cnt_r == ACC_LAST) begin
                        rdata   <= NF_D;
                        NF_OE   <= 1'b1;
                        NF_CE   <= 1'b1;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WR_PULSE: begin
                    if (cnt_r == WP_LAST) begin
                        NF_WE   <= 1'b1;
                        state_r <= WR_HOLD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    // Data and address stay put for one cycle after the WE rising edge.
                    d_oe_r <= 1'b0;
                    NF_CE  <= 1'b1;
                    cnt_r  <= '0;
                    if (is_prog_s && !phase2_r) begin
                        state_r <= REC;
                    end else if (is_prog_s) begin
                        state_r <= STS_WAIT;
                    end else begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                REC: begin
                    // Chip-enable recovery between the command and data phases.
                    phase2_r <= 1'b1;
                    NF_CE    <= 1'b0;
                    d_oe_r   <= 1'b1;
                    d_out_r  <= wdata_r;
                    state_r  <= SETUP;
                end
                STS_WAIT: begin
                    // The first cycles are ignored because the flash needs time
                    // to pull the busy line low.
                    if ((cnt_r >= STS_IGN) && sts_sync_r) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (cnt_r >= STS_LAST) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    ready   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    cnt_r   <= '0;
                    d_oe_r  <= 1'b0;
                    ready   <= 1'b0;
                    NF_CE   <= 1'b1;
                    NF_OE   <= 1'b1;
                    NF_WE   <= 1'b1;
                    NF_RP   <= 1'b0;
                    state_r <= RSTW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_bridge.sv
// Bench for flash_bridge.
// A timeline model derives the expected bus and host outputs for every cycle
// from the operation's offset since acceptance. A compare process checks the
// DUT against that model at every falling edge. Directed and random operations
// drive the DUT, and hand-computed literals pin the model's timing.
module tb_flash_bridge;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;
    localparam int T_ACC  = 6;
    localparam int T_WP   = 4;
    localparam int RP_CYC = 16;
    localparam int STS_TO = 120;
    localparam int W0     = 2 * T_WP + 5;   // offset at which the status wait begins

    logic              CLK_50MHZ = 1'b0;
    logic              RST;
    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready, done, err;
    logic [DATA_W-1:0] rdata;
    logic              NF_CE, NF_OE, NF_WE, NF_RP, NF_BYTE, NF_WP;
    logic [ADDR_W-1:0] NF_A;
    wire  [DATA_W-1:0] NF_D;
    logic              NF_STS;

    int n_cmp = 0;
    int n_bad = 0;

    flash_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ACC(T_ACC), .T_WP(T_WP),
        .RP_CYC(RP_CYC), .STS_TO(STS_TO)
    ) dut (
        .CLK_50MHZ(CLK_50MHZ), .RST(RST), .req(req), .op(op), .addr(addr),
        .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .err(err),
        .NF_CE(NF_CE), .NF_OE(NF_OE), .NF_WE(NF_WE), .NF_RP(NF_RP),
        .NF_BYTE(NF_BYTE), .NF_WP(NF_WP), .NF_A(NF_A), .NF_D(NF_D),
        .NF_STS(NF_STS)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    // Flash array contents: a simple function of the address.
    function automatic logic [7:0] flash_val(input logic [23:0] a);
        return a[7:0] + a[15:8] + 8'h81;
    endfunction

    // The flash drives the bus whenever it is selected with output enable low.
    assign NF_D = (!NF_OE && !NF_CE) ? flash_val(NF_A) : 8'hzz;

    // Log of every bus write, captured on the rising edge of WE.
    logic [7:0] wlog[$];
    always @(posedge NF_WE) if (!NF_CE) wlog.push_back(NF_D);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_valid = 1'b0, m_rstw = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int         m_since = 0, m_d = 0, m_done_d = -1, m_kind = 0;
    logic [23:0] m_addr = '0, m_a = '0;
    logic [7:0]  m_wd = '0, m_rdata = '0;
    logic        p1 = 1'b0, p2 = 1'b0;

    initial begin
        forever begin
            @(posedge CLK_50MHZ);
            if (RST) begin
                m_valid = 1'b1; m_rstw = 1'b1; m_since = 0; m_busy = 1'b0;
                m_a = '0; m_rdata = '0; m_done = 1'b0; m_err = 1'b0;
            end else if (m_valid) begin
                if (m_rstw) begin
                    m_since++;
                    if (m_since >= RP_CYC) m_rstw = 1'b0;
                end else if (!m_busy) begin
                    if (req) begin
                        m_busy = 1'b1; m_d = 0; m_done_d = -1;
                        m_kind = (op == 2'b01) ? 1 : (op == 2'b10) ? 2 : 0;
                        m_addr = addr; m_a = addr; m_wd = wdata;
                    end
                end else begin
                    m_d++;
                    if (m_done_d >= 0 && m_d == m_done_d + 1) begin
                        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
                    end else if (m_kind == 0 && m_d == T_ACC + 1) begin
                        m_done_d = m_d; m_done = 1'b1; m_rdata = flash_val(m_addr);
                    end else if (m_kind == 1 && m_d == T_WP + 2) begin
                        m_done_d = m_d; m_done = 1'b1;
                    end else if (m_kind == 2 && m_done_d < 0 && m_d > W0) begin
                        // k = status-wait cycles completed; the synchronised
                        // pin seen now is the raw pin from two edges back.
                        int k;
                        k = m_d - 1 - W0;
                        if (k >= 4 && p2) begin
                            m_done_d = m_d; m_done = 1'b1; m_err = 1'b0;
                        end else if (k + 1 >= STS_TO) begin
                            m_done_d = m_d; m_done = 1'b1; m_err = 1'b1;
                        end
                    end
                end
            end
            p2 = p1;
            p1 = NF_STS;
        end
    end

    // Expected bus controls for one write phase at phase offset e.
    task automatic wr_phase(input int e, input logic [7:0] v,
                            output bit ce, output bit we, output bit drv, output logic [7:0] dv);
        ce = 1'b0; drv = 1'b1; dv = v;
        we = (e >= 1 && e <= T_WP) ? 1'b0 : 1'b1;
    endtask

    // Compare process
    initial begin
        forever begin
            bit ce, oe, we, drv;
            logic [7:0] dv;
            @(negedge CLK_50MHZ);
            if (m_valid) begin
                ce = 1'b1; oe = 1'b1; we = 1'b1; drv = 1'b0; dv = 8'h00;
                if (!m_rstw && m_busy && !(m_done_d >= 0 && m_d >= m_done_d)) begin
                    if (m_kind == 0) begin
                        ce = 1'b0;
                        oe = (m_d >= 1) ? 1'b0 : 1'b1;
                    end else if (m_kind == 1) begin
                        wr_phase(m_d, m_wd, ce, we, drv, dv);
                    end else if (m_d <= T_WP + 1) begin
                        wr_phase(m_d, 8'h40, ce, we, drv, dv);
                    end else if (m_d >= T_WP + 3 && m_d <= 2 * T_WP + 4) begin
                        wr_phase(m_d - T_WP - 3, m_wd, ce, we, drv, dv);
                    end
                end
                chk("ready", 32'(ready), 32'(!m_rstw && !m_busy));
                chk("NF_RP", 32'(NF_RP), 32'(!m_rstw));
                chk("done", 32'(done), 32'(m_done));
                chk("err", 32'(err), 32'(m_err));
                chk("rdata", 32'(rdata), 32'(m_rdata));
                chk("NF_A", 32'(NF_A), 32'(m_a));
                chk("NF_CE", 32'(NF_CE), 32'(ce));
                chk("NF_OE", 32'(NF_OE), 32'(oe));
                chk("NF_WE", 32'(NF_WE), 32'(we));
                chk("NF_BYTE", 32'(NF_BYTE), 32'd0);
                chk("NF_WP", 32'(NF_WP), 32'd0);
                if (drv) chk("NF_D_write", 32'(NF_D), 32'(dv));
                if (!oe) chk("NF_D_read", 32'(NF_D), 32'(flash_val(m_addr)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int g;
        g = 0;
        while (!ready && g < 300) begin
            @(negedge CLK_50MHZ);
            g++;
        end
        if (!ready) chk("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [23:0] a, input logic [7:0] w,
                         input bit hold, input int sts_low,
                         output int t_done, output int oe_lo, output int we_lo, output logic e_at);
        wait_ready();
        op = o; addr = a; wdata = w; req = 1'b1;
        if (o == 2'b10) NF_STS = 1'b0;
        @(negedge CLK_50MHZ);
        if (!hold) req = 1'b0;
        t_done = -1; oe_lo = 0; we_lo = 0; e_at = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (o == 2'b10 && t == sts_low) NF_STS = 1'b1;
            if (!NF_OE) oe_lo++;
            if (!NF_WE) we_lo++;
            if (done) begin
                t_done = t; e_at = err;
                break;
            end
            @(negedge CLK_50MHZ);
        end
        req = 1'b0; NF_STS = 1'b1;
        if (t_done < 0) chk("done_wait", 32'(done), 32'd1);
    endtask

    task automatic reset_latency(output int lat, output int dn);
        lat = -1; dn = 0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge CLK_50MHZ);
            if (done) dn++;
            if (ready) begin
                lat = t;
                break;
            end
        end
    endtask

    initial begin
        int td, ol, wl, lat, dn;
        logic ea;
        RST = 1'b1; req = 1'b0; op = 2'b00; addr = '0; wdata = '0; NF_STS = 1'b1;
        repeat (3) @(posedge CLK_50MHZ);
        @(negedge CLK_50MHZ);
        chk("rst_NF_RP", 32'(NF_RP), 32'd0);
        chk("rst_NF_CE", 32'(NF_CE), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_NF_A", 32'(NF_A), 32'd0);
        RST = 1'b0;
        reset_latency(lat, dn);
        chk("rp_latency", 32'(lat), 32'd16);

        // Read at 0x000123 returns 0xA5
        do_op(2'b00, 24'h000123, 8'h00, 1'b0, 0, td, ol, wl, ea);
        chk("read_done_at", 32'(td), 32'd7);
        chk("read_oe_low", 32'(ol), 32'd6);
        chk("read_rdata", 32'(rdata), 32'h0000_00A5);

        // Raw write of 0x3C
        do_op(2'b01, 24'h000456, 8'h3C, 1'b0, 0, td, ol, wl, ea);
        chk("write_done_at", 32'(td), 32'd6);
        chk("write_we_low", 32'(wl), 32'd4);
        chk("rdata_held", 32'(rdata), 32'h0000_00A5);

        // Program of 0x5A with the busy line low for 100 cycles
        wlog.delete();
        do_op(2'b10, 24'h000789, 8'h5A, 1'b0, 100, td, ol, wl, ea);
        chk("prog_done_at", 32'(td), 32'd103);
        chk("prog_err", 32'(ea), 32'd0);
        chk("prog_we_low", 32'(wl), 32'd8);
        chk("prog_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("prog_cmd", 32'(wlog[0]), 32'h40);
            chk("prog_data", 32'(wlog[1]), 32'h5A);
        end

        // Program with the busy line stuck low; req is held for the whole operation
        do_op(2'b10, 24'h000ABC, 8'h11, 1'b1, 100000, td, ol, wl, ea);
        chk("timeout_done_at", 32'(td), 32'd133);
        chk("timeout_err", 32'(ea), 32'd1);

        // Reserved opcode behaves as a read
        do_op(2'b11, 24'h001020, 8'h00, 1'b0, 0, td, ol, wl, ea);
        chk("rsv_done_at", 32'(td), 32'd7);
        chk("rsv_rdata", 32'(rdata), 32'h0000_00B1);

        // Randomised operations, checked by the model every cycle
        for (int i = 0; i < 30; i++) begin
            int gap;
            do_op(2'($urandom_range(0, 3)), 24'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), td, ol, wl, ea);
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge CLK_50MHZ);
        end

        // Reset in the middle of a read access
        wait_ready();
        op = 2'b00; addr = 24'h00ABCD; req = 1'b1;
        @(negedge CLK_50MHZ);
        req = 1'b0;
        repeat (3) @(negedge CLK_50MHZ);
        chk("abort_oe_before", 32'(NF_OE), 32'd0);
        RST = 1'b1;
        @(negedge CLK_50MHZ);
        chk("abort_oe", 32'(NF_OE), 32'd1);
        chk("abort_ce", 32'(NF_CE), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rp", 32'(NF_RP), 32'd0);
        RST = 1'b0;
        reset_latency(lat, dn);
        chk("abort_rp_latency", 32'(lat), 32'd16);
        chk("abort_no_done", 32'(dn), 32'd0);

        repeat (3) @(negedge CLK_50MHZ);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so that a stuck run still terminates.
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
